aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl_if.sv | 33 +++
 rtl/aes_key_sched_ctrl.sv | 132 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Bundle between the key-schedule controller, its two requesters, the key-expansion
// engine and the round-key consumer. master = controller side, slave = environment side.
interface aes_key_sched_ctrl_if;
  logic [1:0]   req_i;
  logic [127:0] key0_i;
  logic [127:0] key1_i;
  logic [1:0]   gnt_o;
  logic         eng_start_o;
  logic [127:0] eng_key_o;
  logic         eng_done_i;
  logic [3:0]   eng_rk_sel_o;
  logic [127:0] eng_rk_i;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic [127:0] rk_data_o;
  logic [3:0]   rk_idx_o;
  logic         rk_last_o;
  logic         rk_dst_o;
  logic         busy_o;
  logic         err_o;

  modport master (
    input  req_i, key0_i, key1_i, eng_done_i, eng_rk_i, rk_ready_i,
    output gnt_o, eng_start_o, eng_key_o, eng_rk_sel_o, rk_valid_o, rk_data_o,
    output rk_idx_o, rk_last_o, rk_dst_o, busy_o, err_o
  );

  modport slave (
    output req_i, key0_i, key1_i, eng_done_i, eng_rk_i, rk_ready_i,
    input  gnt_o, eng_start_o, eng_key_o, eng_rk_sel_o, rk_valid_o, rk_data_o,
    input  rk_idx_o, rk_last_o, rk_dst_o, busy_o, err_o
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Arbitrates two key requesters onto one AES-128 key-expansion engine, caches the last
// expanded key and streams round keys 0..10 to the granted requester.
module aes_key_sched_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          CACHE_EN       = 1'b1
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  aes_key_sched_ctrl_if.master  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StStream} state_e;

  state_e          state_q;
  logic [1:0]      rst_sync_q;
  logic [1:0]      gnt_q;
  logic            eng_start_q;
  logic [127:0]    eng_key_q;
  logic [3:0]      sel_q;
  logic            dst_q;
  logic            rr_q;
  logic            cache_valid_q;
  logic [127:0]    cache_key_q;
  logic [CntW-1:0] tmo_q;
  logic            err_q;
  logic            rk_valid_q;

  logic         win;
  logic [127:0] win_key;
  logic         hit;

  // Single requesters always win; the rr pointer only breaks ties.
  always_comb begin
    win = rr_q;
    if (bus.req_i == 2'b01) win = 1'b0;
    if (bus.req_i == 2'b10) win = 1'b1;
    win_key = win ? bus.key1_i : bus.key0_i;
    hit     = CACHE_EN && cache_valid_q && (win_key == cache_key_q);
  end

  // Reset release is re-timed so no grant can happen in the release cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      gnt_q         <= 2'b00;
      eng_start_q   <= 1'b0;
      eng_key_q     <= '0;
      sel_q         <= '0;
      dst_q         <= 1'b0;
      rr_q          <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      tmo_q         <= '0;
      err_q         <= 1'b0;
      rk_valid_q    <= 1'b0;
    end else begin
      gnt_q       <= 2'b00;
      eng_start_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rst_sync_q[1] && (bus.req_i != 2'b00)) begin
            gnt_q     <= win ? 2'b10 : 2'b01;
            eng_key_q <= win_key;
            dst_q     <= win;
            if (hit) begin
              state_q <= StStream;
            end else begin
              state_q     <= StStart;
              eng_start_q <= 1'b1;
            end
          end
        end
        StStart: begin
          state_q <= StWait;
          tmo_q   <= '0;
        end
        StWait: begin
          // tmo_q == 0 marks the first WAIT cycle, where a stale done is ignored.
          if ((tmo_q != '0) && bus.eng_done_i) begin
            state_q       <= StStream;
            rk_valid_q    <= 1'b1;
            cache_key_q   <= eng_key_q;
            cache_valid_q <= 1'b1;
          end else if (tmo_q == TmoLast) begin
            state_q       <= StIdle;
            err_q         <= 1'b1;
            cache_valid_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StStream: begin
          if (!rk_valid_q) begin
            rk_valid_q <= 1'b1;
          end else if (bus.rk_ready_i) begin
            if (sel_q == 4'd10) begin
              state_q    <= StIdle;
              rk_valid_q <= 1'b0;
              sel_q      <= '0;
              rr_q       <= ~rr_q;
            end else begin
              sel_q <= sel_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt_o        = gnt_q;
  assign bus.eng_start_o  = eng_start_q;
  assign bus.eng_key_o    = eng_key_q;
  assign bus.eng_rk_sel_o = sel_q;
  assign bus.rk_valid_o   = rk_valid_q;
  assign bus.rk_data_o    = bus.eng_rk_i;
  assign bus.rk_idx_o     = sel_q;
  assign bus.rk_last_o    = (sel_q == 4'd10);
  assign bus.rk_dst_o     = dst_q;
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: a vector table of requests plus a mid-stream reset
// sequence, against a behavioural AES-128 key-expansion engine.
module tb_aes_key_sched_ctrl;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] KA     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KC     = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] RK10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [1:0]   req;
    logic [127:0] key0;
    logic [127:0] key1;
    bit           stall;
    bit           hang;
    bit           hold;
    logic [1:0]   exp_gnt;
    bit           exp_start;
    bit           exp_err;
  } vec_t;

  logic clk;
  logic rst_ni;
  int   checks = 0;
  int   fails  = 0;
  bit   hang_en = 1'b0;

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl #(
    .TIMEOUT_CYCLES(8),
    .CACHE_EN      (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 44; j++) r[1407 - 32 * j -: 32] = w[j];
    return r;
  endfunction

  // Behavioural engine: done rises a few cycles after start, stays high until next start.
  logic [1407:0] eng_rks;
  logic          eng_done;
  int            eng_cnt;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      eng_done <= 1'b0;
      eng_cnt  <= 0;
    end else if (bus.eng_start_o) begin
      eng_rks  <= expand(bus.eng_key_o);
      eng_done <= 1'b0;
      eng_cnt  <= hang_en ? 0 : 3;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_done <= 1'b1;
    end
  end

  assign bus.eng_done_i = eng_done;
  always_comb begin
    bus.eng_rk_i = '0;
    if (bus.eng_rk_sel_o <= 4'd10) bus.eng_rk_i = eng_rks[1407 - 128 * int'(bus.eng_rk_sel_o) -: 128];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int id, input vec_t v);
    logic [127:0]  wkey;
    logic [1407:0] exp_rks;
    logic [127:0]  prev_data;
    logic [3:0]    prev_idx;
    int            beat, starts, err_cyc;
    bit            got, err_seen, stalled;
    hang_en        = v.hang;
    bus.key0_i     = v.key0;
    bus.key1_i     = v.key1;
    bus.req_i      = v.req;
    bus.rk_ready_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt_o != 2'b00) got = 1'b1;
    end
    chk($sformatf("v%0d_granted", id), got, 1);
    if (!got) begin
      bus.req_i = 2'b00;
      return;
    end
    wkey    = v.exp_gnt[1] ? v.key1 : v.key0;
    exp_rks = expand(wkey);
    chk($sformatf("v%0d_gnt", id), bus.gnt_o, v.exp_gnt);
    if (!v.hold) begin
      bus.req_i  = 2'b00;
      bus.key0_i = ~v.key0;
      bus.key1_i = ~v.key1;
    end
    chk($sformatf("v%0d_eng_key", id), bus.eng_key_o, wkey);
    chk($sformatf("v%0d_dst", id), bus.rk_dst_o, v.exp_gnt[1]);
    if (!v.exp_start) chk($sformatf("v%0d_hit_valid_c0", id), bus.rk_valid_o, 0);
    starts   = int'(bus.eng_start_o);
    beat     = 0;
    err_seen = 1'b0;
    err_cyc  = 0;
    stalled  = 1'b0;
    for (int cyc = 1; cyc < 200 && beat < 11 && !err_seen; cyc++) begin
      @(negedge clk);
      if (bus.eng_start_o) starts++;
      if (bus.gnt_o != 2'b00) chk($sformatf("v%0d_gnt_outside_idle", id), bus.gnt_o, 0);
      if (bus.err_o) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
        chk($sformatf("v%0d_busy_after_err", id), bus.busy_o, 0);
      end
      if (!v.exp_start && cyc == 1) chk($sformatf("v%0d_hit_valid_c1", id), bus.rk_valid_o, 1);
      if (bus.rk_valid_o) begin
        chk($sformatf("v%0d_b%0d_idx", id, beat), bus.rk_idx_o, beat);
        chk($sformatf("v%0d_b%0d_sel", id, beat), bus.eng_rk_sel_o, beat);
        chk($sformatf("v%0d_b%0d_data", id, beat), bus.rk_data_o, exp_rks[1407 - 128 * beat -: 128]);
        chk($sformatf("v%0d_b%0d_last", id, beat), bus.rk_last_o, beat == 10);
        chk($sformatf("v%0d_b%0d_dst", id, beat), bus.rk_dst_o, v.exp_gnt[1]);
        if (wkey == KA && beat == 10) chk($sformatf("v%0d_rk10_fips", id), bus.rk_data_o, RK10_A);
        if (stalled) begin
          chk($sformatf("v%0d_stall_idx", id), bus.rk_idx_o, prev_idx);
          chk($sformatf("v%0d_stall_data", id), bus.rk_data_o, prev_data);
        end
      end
      bus.rk_ready_i = v.stall ? (cyc % 2 == 1) : 1'b1;
      stalled   = bus.rk_valid_o && !bus.rk_ready_i;
      prev_idx  = bus.rk_idx_o;
      prev_data = bus.rk_data_o;
      if (bus.rk_valid_o && bus.rk_ready_i) beat++;
    end
    chk($sformatf("v%0d_starts", id), starts, v.exp_start);
    chk($sformatf("v%0d_err", id), err_seen, v.exp_err);
    if (v.exp_err) begin
      chk($sformatf("v%0d_err_cycle", id), err_cyc, 9);
    end else begin
      chk($sformatf("v%0d_beats", id), beat, 11);
      @(negedge clk);
      chk($sformatf("v%0d_end_busy", id), bus.busy_o, 0);
      chk($sformatf("v%0d_end_valid", id), bus.rk_valid_o, 0);
      chk($sformatf("v%0d_end_idx", id), bus.rk_idx_o, 0);
    end
    bus.rk_ready_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, bus.gnt_o, 0);
    chk({tag, "_start"}, bus.eng_start_o, 0);
    chk({tag, "_valid"}, bus.rk_valid_o, 0);
    chk({tag, "_idx"}, bus.rk_idx_o, 0);
    chk({tag, "_sel"}, bus.eng_rk_sel_o, 0);
    chk({tag, "_last"}, bus.rk_last_o, 0);
    chk({tag, "_dst"}, bus.rk_dst_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_eng_key"}, bus.eng_key_o, 0);
  endtask

  vec_t vecs [11];

  initial begin
    bit got;
    // req, key0, key1, stall, hang, hold, exp_gnt, exp_start, exp_err
    vecs[0]  = '{2'b01, KA, KB, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0}; // cold miss
    vecs[1]  = '{2'b10, KC, KA, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0}; // hit via req 1
    vecs[2]  = '{2'b01, KB, KC, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0}; // backpressure
    vecs[3]  = '{2'b01, KC, KA, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1}; // timeout
    vecs[4]  = '{2'b11, KA, KB, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0}; // rr kept, cache dropped
    vecs[5]  = '{2'b10, KC, KC, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, KC, KA, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0}; // hit via req 0
    vecs[7]  = '{2'b11, KA, KB, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0}; // contention held
    vecs[8]  = '{2'b11, KA, KB, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0};
    vecs[9]  = '{2'b11, KA, KB, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    vecs[10] = '{2'b11, KA, KB, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0}; // after reset

    bus.req_i      = 2'b00;
    bus.key0_i     = '0;
    bus.key1_i     = '0;
    bus.rk_ready_i = 1'b0;
    rst_ni         = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

    // Reset while beat 5 is on the bus.
    bus.key1_i     = KA;
    bus.req_i      = 2'b10;
    got            = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt_o != 2'b00) got = 1'b1;
    end
    chk("rst_seq_granted", got, 1);
    bus.req_i      = 2'b00;
    bus.rk_ready_i = 1'b1;
    got            = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.rk_valid_o && bus.rk_idx_o == 4'd5) got = 1'b1;
    end
    chk("rst_seq_reach_beat5", got, 1);
    chk("rst_seq_dst_before", bus.rk_dst_o, 1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    bus.req_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("in_rst_gnt%0d", i), bus.gnt_o, 0);
      chk($sformatf("in_rst_valid%0d", i), bus.rk_valid_o, 0);
    end
    rst_ni         = 1'b1;
    bus.req_i      = 2'b00;
    bus.rk_ready_i = 1'b0;
    run_txn(10, vecs[10]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
